// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage types and constants
package fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic {S_WAIT, S_SKID} fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry pc+instr holding register for a response the slot cannot take
module fetch_skid_buf
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);
  logic [XLEN-1:0] pc_q, instr_q;
  // capture on load, clear once the entry is handed on or flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (unload_i) begin
      pc_q    <= '0;
      instr_q <= '0;
    end
  end
  assign pc_o    = pc_q;
  assign instr_o = instr_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with output slot, skid entry and redirect squash
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_F,
  input  logic            PCSrcD,
  input  logic [XLEN-1:0] PCBranchD,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PC_F,
  output logic [XLEN-1:0] Instr_F,
  output logic [XLEN-1:0] PC_Plus4_F,
  output logic            Valid_F
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d, next_pc_q, next_pc_d;
  logic [XLEN-1:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d;
  logic            valid_q, valid_d, squash_q, squash_d;
  logic            skid_load, skid_unload, consume;
  logic [XLEN-1:0] skid_pc, skid_instr;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .pc_i     (req_pc_q),
    .instr_i  (imem_rdata),
    .pc_o     (skid_pc),
    .instr_o  (skid_instr)
  );

  // state, request pointer, redirect target and output slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_WAIT;
      req_pc_q  <= RESET_PC;
      next_pc_q <= RESET_PC;
      pc_q      <= '0;
      instr_q   <= '0;
      pc4_q     <= '0;
      valid_q   <= 1'b0;
      squash_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      next_pc_q <= next_pc_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc4_q     <= pc4_d;
      valid_q   <= valid_d;
      squash_q  <= squash_d;
    end
  end

  // next state: redirect first, then skid drain, then memory response, then plain consumption
  always_comb begin
    state_d     = state_q;
    req_pc_d    = req_pc_q;
    next_pc_d   = next_pc_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    squash_d    = squash_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    consume     = valid_q && !stall_F;
    if (PCSrcD) begin
      valid_d     = 1'b0;
      skid_unload = 1'b1;
      state_d     = S_WAIT;
      if (state_q == S_SKID || imem_rvalid) begin
        req_pc_d = PCBranchD;
        squash_d = 1'b0;
      end else begin
        next_pc_d = PCBranchD;
        squash_d  = 1'b1;
      end
    end else if (state_q == S_SKID) begin
      if (!stall_F) begin
        pc_d        = skid_pc;
        instr_d     = skid_instr;
        pc4_d       = skid_pc + PC_INC;
        skid_unload = 1'b1;
        state_d     = S_WAIT;
      end
    end else if (imem_rvalid) begin
      if (squash_q) begin
        squash_d = 1'b0;
        req_pc_d = next_pc_q;
        valid_d  = consume ? 1'b0 : valid_q;
      end else if (!valid_q || !stall_F) begin
        pc_d     = req_pc_q;
        instr_d  = imem_rdata;
        pc4_d    = req_pc_q + PC_INC;
        valid_d  = 1'b1;
        req_pc_d = req_pc_q + PC_INC;
      end else begin
        skid_load = 1'b1;
        req_pc_d  = req_pc_q + PC_INC;
        state_d   = S_SKID;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  assign imem_req   = (state_q == S_WAIT);
  assign imem_addr  = req_pc_q;
  assign PC_F       = pc_q;
  assign Instr_F    = instr_q;
  assign PC_Plus4_F = pc4_q;
  assign Valid_F    = valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario bench for fetch_unit with a one-cycle instruction memory model
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_F = 1'b0;
  logic        PCSrcD = 1'b0;
  logic [31:0] PCBranchD = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC_F, Instr_F, PC_Plus4_F;
  logic        Valid_F;
  logic        hold = 1'b0;
  int          checks = 0;
  int          errors = 0;
  bit          ok;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_F     (stall_F),
    .PCSrcD      (PCSrcD),
    .PCBranchD   (PCBranchD),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .PC_F        (PC_F),
    .Instr_F     (Instr_F),
    .PC_Plus4_F  (PC_Plus4_F),
    .Valid_F     (Valid_F)
  );

  always #5 clk = ~clk;

  // memory answers one cycle after a request is seen; the word is the inverted address
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      imem_rvalid <= imem_req && !imem_rvalid && !hold;
      imem_rdata  <= ~imem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hold = 1'b0;
    stall_F = 1'b0;
    PCSrcD = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (Valid_F) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) begin
      errors++;
      $display("FAIL wait_valid: Valid_F never rose within 20 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tick();
    checks += 4;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_req: got %b want 1", imem_req); end
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    if (Valid_F !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", Valid_F); end
    if (PC_F !== 32'h0 || Instr_F !== 32'h0 || PC_Plus4_F !== 32'h0) begin
      errors++; $display("FAIL rst_slot: got %h %h %h want 0 0 0", PC_F, Instr_F, PC_Plus4_F);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'(k * 4);
      wait_valid(ok);
      checks += 3;
      if (PC_F !== exp_pc) begin errors++; $display("FAIL stream_pc%0d: got %h want %h", k, PC_F, exp_pc); end
      if (Instr_F !== ~exp_pc) begin errors++; $display("FAIL stream_instr%0d: got %h want %h", k, Instr_F, ~exp_pc); end
      if (PC_Plus4_F !== exp_pc + 32'd4) begin errors++; $display("FAIL stream_pc4_%0d: got %h want %h", k, PC_Plus4_F, exp_pc + 32'd4); end
      tick();
    end
  endtask

  task automatic test_skid();
    do_reset();
    wait_valid(ok);
    checks++;
    if (PC_F !== 32'h0) begin errors++; $display("FAIL skid_pc0: got %h want 0", PC_F); end
    tick();
    wait_valid(ok);
    checks++;
    if (PC_F !== 32'h4) begin errors++; $display("FAIL skid_pc4: got %h want 4", PC_F); end
    stall_F = 1'b1;
    tick();
    tick();
    checks += 3;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL skid_req_low: got %b want 0", imem_req); end
    if (imem_addr !== 32'hC) begin errors++; $display("FAIL skid_addr: got %h want c", imem_addr); end
    if (Valid_F !== 1'b1 || PC_F !== 32'h4) begin errors++; $display("FAIL skid_hold: got v=%b pc=%h want v=1 pc=4", Valid_F, PC_F); end
    tick();
    checks++;
    if (imem_req !== 1'b0 || Valid_F !== 1'b1 || PC_F !== 32'h4) begin
      errors++; $display("FAIL skid_stall3: got req=%b v=%b pc=%h want 0 1 4", imem_req, Valid_F, PC_F);
    end
    stall_F = 1'b0;
    tick();
    checks += 3;
    if (PC_F !== 32'h8 || Instr_F !== ~32'h8) begin errors++; $display("FAIL skid_drain: got %h %h want 8 %h", PC_F, Instr_F, ~32'h8); end
    if (Valid_F !== 1'b1) begin errors++; $display("FAIL skid_valid: got %b want 1", Valid_F); end
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL skid_resume: got req=%b addr=%h want 1 c", imem_req, imem_addr); end
    tick();
    wait_valid(ok);
    checks++;
    if (PC_F !== 32'hC) begin errors++; $display("FAIL skid_next: got %h want c", PC_F); end
    tick();
  endtask

  task automatic test_redirect_squash();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      wait_valid(ok);
      if (k == 3) hold = 1'b1;
      tick();
    end
    checks++;
    if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin errors++; $display("FAIL sq_pending: got req=%b addr=%h want 1 10", imem_req, imem_addr); end
    PCSrcD = 1'b1;
    PCBranchD = 32'h100;
    tick();
    PCSrcD = 1'b0;
    checks += 2;
    if (imem_addr !== 32'h10) begin errors++; $display("FAIL sq_addr_held: got %h want 10", imem_addr); end
    if (Valid_F !== 1'b0) begin errors++; $display("FAIL sq_valid_clr: got %b want 0", Valid_F); end
    hold = 1'b0;
    tick();
    tick();
    checks += 2;
    if (Valid_F !== 1'b0) begin errors++; $display("FAIL sq_discard: got %b want 0", Valid_F); end
    if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL sq_target: got req=%b addr=%h want 1 100", imem_req, imem_addr); end
    wait_valid(ok);
    checks++;
    if (PC_F !== 32'h100 || Instr_F !== ~32'h100) begin errors++; $display("FAIL sq_first: got %h %h want 100 %h", PC_F, Instr_F, ~32'h100); end
    tick();
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    tick();
    PCSrcD = 1'b1;
    PCBranchD = 32'h200;
    tick();
    PCSrcD = 1'b0;
    checks += 2;
    if (imem_addr !== 32'h200 || imem_req !== 1'b1) begin errors++; $display("FAIL sc_addr: got req=%b addr=%h want 1 200", imem_req, imem_addr); end
    if (Valid_F !== 1'b0) begin errors++; $display("FAIL sc_drop: got %b want 0", Valid_F); end
    wait_valid(ok);
    checks++;
    if (PC_F !== 32'h200 || Instr_F !== ~32'h200) begin errors++; $display("FAIL sc_first: got %h %h want 200 %h", PC_F, Instr_F, ~32'h200); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    PCSrcD = 1'b1;
    PCBranchD = 32'hFFFF_FFFC;
    tick();
    PCSrcD = 1'b0;
    wait_valid(ok);
    checks += 2;
    if (PC_F !== 32'hFFFF_FFFC || PC_Plus4_F !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h %h want fffffffc 0", PC_F, PC_Plus4_F); end
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
    tick();
    wait_valid(ok);
    checks++;
    if (PC_F !== 32'h0 || Instr_F !== ~32'h0) begin errors++; $display("FAIL wrap_next: got %h %h want 0 %h", PC_F, Instr_F, ~32'h0); end
    tick();
  endtask

  task automatic test_reset_mid_skid();
    do_reset();
    wait_valid(ok);
    stall_F = 1'b1;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL ms_in_skid: got req=%b want 0", imem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (Valid_F !== 1'b0 || PC_F !== 32'h0) begin errors++; $display("FAIL ms_slot: got v=%b pc=%h want 0 0", Valid_F, PC_F); end
    if (Instr_F !== 32'h0 || PC_Plus4_F !== 32'h0) begin errors++; $display("FAIL ms_data: got %h %h want 0 0", Instr_F, PC_Plus4_F); end
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL ms_req: got req=%b addr=%h want 1 0", imem_req, imem_addr); end
    stall_F = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_valid(ok);
    checks++;
    if (PC_F !== 32'h0 || Instr_F !== ~32'h0) begin errors++; $display("FAIL ms_restart: got %h %h want 0 %h", PC_F, Instr_F, ~32'h0); end
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_redirect_squash();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_mid_skid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 stall_F  input  1  IF_ID not accepting; the output slot is consumed on any edge with Valid_F=1 and stall_F=0.
REQ-005 PCSrcD  input  1  branch/jump redirect from ID.
REQ-006 PCBranchD  input  32  redirect target, sampled when PCSrcD=1.
REQ-007 imem_req  output  1  instruction-memory request, registered.
REQ-008 imem_addr  output  32  request address, registered, stable while a request is outstanding.
REQ-009 imem_rvalid  input  1  completes the outstanding request; earliest one cycle after the request is issued.
REQ-010 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-011 PC_F, Instr_F, PC_Plus4_F  output  32 each  fetched instruction address, word and address+4, to IF_ID.
REQ-012 Valid_F  output  1  output slot holds a live instruction.

Function
REQ-013 Memory protocol: one outstanding request; if imem_req is high on the cycle after imem_rvalid, it is a new request at the current imem_addr.
REQ-014 States: WAIT (imem_req=1) and SKID (imem_req=0); reset state is WAIT.
REQ-015 Registers: req_pc (drives imem_addr), next_pc, output slot, one-entry skid (pc, instr), squash flag.
REQ-016 WAIT, unsquashed rvalid, slot free or draining (Valid_F=0 or stall_F=0): load the slot with {req_pc, imem_rdata, req_pc+4}; Valid_F=1; req_pc<=req_pc+4; stay in WAIT.
REQ-017 WAIT, unsquashed rvalid, Valid_F=1 and stall_F=1: capture into the skid; req_pc<=req_pc+4; go to SKID.
REQ-018 SKID, stall_F=0: move the skid into the slot; Valid_F stays 1; go to WAIT.
REQ-019 Slot consumed with no refill: Valid_F<=0 on that edge.
REQ-020 PC_Plus4_F is PC_F+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-021 A PCSrcD edge has priority over stall and response: it clears Valid_F and the skid and forces state WAIT.
REQ-022 Redirect while a request is outstanding with no rvalid that cycle: set squash, next_pc<=PCBranchD, req_pc unchanged.
REQ-023 Redirect on the cycle rvalid arrives: discard the response and set req_pc<=PCBranchD; squash stays clear.
REQ-024 Redirect in SKID: req_pc<=PCBranchD, imem_req rises on the next cycle.
REQ-025 Squashed rvalid: discard the data, clear squash, req_pc<=next_pc; Valid_F is not set.
REQ-026 Redirect with squash already set: only next_pc is updated.
REQ-027 Valid_F never changes because of stall_F alone.
REQ-028 An instruction is never lost or duplicated.

Reset
REQ-029 On rst_n low, immediately and regardless of clk: state=WAIT; req_pc=next_pc=RESET_PC; PC_F=Instr_F=PC_Plus4_F=0; Valid_F=0; squash=0; skid cleared.
REQ-030 While rst_n is low, imem_req=1 and imem_addr=RESET_PC.
REQ-031 Reset mid-operation abandons any outstanding request; the memory is reset by the same rst_n.
REQ-032 Release of rst_n is synchronised to clk by the system.

Structure
REQ-033 Shared pipeline package holds: the fetch state enumeration, the 32-bit word width constant, the PC increment constant 4, and the default RESET_PC.
REQ-034 The skid entry is the sole natural sub-module: fetch_skid_buf, a one-entry pc+instr holding register with load and unload controls.

Verification
REQ-035 Reset, 1-cycle memory, stall_F=0 -> addresses 0, 4, 8 issued back-to-back; Valid_F=1 from the 2nd cycle; PC_F=0, 4, 8 with matching Instr_F.
REQ-036 Slot full, stall_F held 3 cycles while rvalid returns at address 8 -> state SKID, imem_req=0; on release PC_F=8 next, then fetch resumes at 12.
REQ-037 Redirect to 32'h0000_0100 while a request to 0x10 is outstanding -> 0x10 response discarded; next request at 0x100; first valid PC_F=0x100.
REQ-038 PCSrcD on the same cycle as rvalid -> data dropped, no squash, imem_addr=target the next cycle.
REQ-039 req_pc=32'hFFFF_FFFC -> PC_Plus4_F=0; next request at address 0.
REQ-040 rst_n pulsed low mid-SKID -> all outputs 0 within the same cycle; restart at RESET_PC.
